// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: LSB-first frames of N bits, started by sync,
// delivered through a single-entry holding register with a sticky overrun flag.
module shift_deserializer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sync,
   input  logic         si,
   input  logic         si_en,
   input  logic         rd,
   output logic [N-1:0] q,
   output logic         q_valid,
   output logic         busy,
   output logic         overrun
);

   localparam int CW = $clog2(N + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RECV = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  shreg;
   logic [N-1:0]  word;
   logic          accept;
   logic          last;

   // A sync always restarts at bit 0, so it can never complete a word (N >= 2).
   always_comb begin
      accept = si_en && (sync || (state == RECV));
      word   = {si, shreg[N-1:1]};
      last   = si_en && !sync && (state == RECV) && (cnt == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (accept)
            shreg <= word;

         if (sync) begin
            state <= RECV;
            cnt   <= si_en ? CW'(1) : '0;
         end else if ((state == RECV) && si_en) begin
            if (last) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         // A completed word only lands if the holding register is free or being read now.
         if (last) begin
            if (!q_valid || rd) begin
               q       <= word;
               q_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd && q_valid) begin
            q_valid <= 1'b0;
         end
      end
   end

   assign busy = (state == RECV);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed and randomized checks of shift_deserializer against a frame-level model.
module tb_shift_deserializer;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sync = 1'b0;
   logic         si = 1'b0;
   logic         si_en = 1'b0;
   logic         rd = 1'b0;
   logic [N-1:0] q;
   logic         q_valid;
   logic         busy;
   logic         overrun;

   int tests = 0;
   int fails = 0;
   string tag = "init";

   // Model: frame in progress, bit index, word assembled by arithmetic
   int           m_busy = 0;
   int           m_cnt = 0;
   int           m_word = 0;
   logic [N-1:0] m_q = '0;
   logic         m_qv = 1'b0;
   logic         m_ovr = 1'b0;

   shift_deserializer #(.N(N)) dut (
      .clk(clk), .reset(reset), .sync(sync), .si(si), .si_en(si_en), .rd(rd),
      .q(q), .q_valid(q_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic model(input logic r, input logic s, input logic d, input logic e, input logic rdi);
      logic done;
      done = 1'b0;
      if (r) begin
         m_busy = 0; m_cnt = 0; m_word = 0; m_q = '0; m_qv = 1'b0; m_ovr = 1'b0;
      end else begin
         if (s) begin
            m_busy = 1;
            m_cnt  = e ? 1 : 0;
            m_word = e ? int'(d) : 0;
         end else if (m_busy != 0 && e) begin
            m_word = m_word + (int'(d) << m_cnt);
            m_cnt  = m_cnt + 1;
            if (m_cnt == N) begin
               done   = 1'b1;
               m_busy = 0;
            end
         end
         if (done) begin
            if (!m_qv || rdi) begin
               m_q  = m_word[N-1:0];
               m_qv = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (rdi && m_qv) begin
            m_qv = 1'b0;
         end
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s %s: got %b want %b", tag, name, got, want);
      end
   endtask

   task automatic check_q(input logic [N-1:0] want);
      tests++;
      assert (q === want) else begin
         fails++;
         $error("FAIL %s q: got %h want %h", tag, q, want);
      end
   endtask

   task automatic check_all();
      check_q(m_q);
      check_bit("q_valid", q_valid, m_qv);
      check_bit("busy", busy, (m_busy != 0));
      check_bit("overrun", overrun, m_ovr);
   endtask

   task automatic cycle(input logic r, input logic s, input logic d, input logic e, input logic rdi);
      reset = r; sync = s; si = d; si_en = e; rd = rdi;
      @(posedge clk);
      #1;
      model(r, s, d, e, rdi);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [N-1:0] bits, input logic rd_last);
      cycle(1'b0, 1'b1, bits[0], 1'b1, 1'b0);
      for (int i = 1; i < N - 1; i++) cycle(1'b0, 1'b0, bits[i], 1'b1, 1'b0);
      cycle(1'b0, 1'b0, bits[N-1], 1'b1, rd_last);
   endtask

   initial begin
      logic [N-1:0] bits;

      tag = "reset";
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check_q('0);
      check_bit("q_valid_const", q_valid, 1'b0);

      tag = "basic";
      idle(1);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_bit("no_early_valid", q_valid, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_q(4'hD);
      check_bit("valid_const", q_valid, 1'b1);
      check_bit("busy_const", busy, 1'b0);
      idle(1);

      tag = "overrun";
      send_frame(4'h0, 1'b0);
      check_q(4'hD);
      check_bit("overrun_const", overrun, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_bit("valid_cleared", q_valid, 1'b0);
      check_bit("overrun_sticky", overrun, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      tag = "rd_same_cycle";
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(4'hD, 1'b0);
      idle(2);
      send_frame(4'hF, 1'b1);
      check_q(4'hF);
      check_bit("valid_const", q_valid, 1'b1);
      check_bit("no_overrun", overrun, 1'b0);

      tag = "resync";
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_bit("no_early_valid", q_valid, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check_q(4'hE);
      check_bit("valid_const", q_valid, 1'b1);

      tag = "mid_reset";
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check_bit("busy_const", busy, 1'b0);
      check_q('0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'(i), 1'b1, 1'b0);
      check_bit("no_valid_nosync", q_valid, 1'b0);

      tag = "gaps";
      for (int rep = 0; rep < 4; rep++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         bits = 4'hD;
         cycle(1'b0, 1'b1, bits[0], 1'b1, 1'b0);
         for (int i = 1; i < N; i++) begin
            idle($urandom_range(0, 5));
            cycle(1'b0, 1'b0, bits[i], 1'b1, 1'b0);
         end
         check_q(4'hD);
         check_bit("valid_const", q_valid, 1'b1);
      end

      tag = "random";
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the parallel word width in bits (N >= 2).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port sync SHALL be an input, 1 bit: frame-start strobe.
REQ-005 Port si SHALL be an input, 1 bit: serial data bit.
REQ-006 Port si_en SHALL be an input, 1 bit: si is a valid data bit this cycle.
REQ-007 Port rd SHALL be an input, 1 bit: the consumer takes the word on q this cycle.
REQ-008 Port q SHALL be an output, N bits: last completed word, held stable while q_valid=1.
REQ-009 Port q_valid SHALL be an output, 1 bit: q holds an unconsumed word.
REQ-010 Port busy SHALL be an output, 1 bit: a frame is in progress (state RECV).
REQ-011 Port overrun SHALL be an output, 1 bit: sticky flag set when a completed word was dropped.

Function
REQ-012 Bit order SHALL be LSB first: the first accepted bit of a frame lands in q[0] and the Nth in q[N-1].
REQ-013 The internal shift register SHALL shift right on each accepted bit, with si entering at bit N-1.
REQ-014 The FSM SHALL have two states: IDLE and RECV.
REQ-015 In IDLE, si_en without sync SHALL be ignored, and the shift register and bit counter SHALL stay unchanged.
REQ-016 In IDLE, sync=1 SHALL move the FSM to RECV with the bit counter cleared.
REQ-017 If si_en=1 in the same cycle as sync, that bit SHALL be accepted as bit 0 and the counter SHALL become 1.
REQ-018 In RECV, each cycle with si_en=1 and sync=0 SHALL accept one bit and increment the counter.
REQ-019 In RECV, sync=1 SHALL abort the partial frame and restart at bit 0, applying the same same-cycle si_en rule as REQ-017; q and q_valid SHALL be unaffected.
REQ-020 On the cycle the Nth bit is accepted, the word SHALL be complete and the FSM SHALL return to IDLE on the next edge.
REQ-021 Word completion SHALL have 1-cycle latency: q and q_valid update on the edge that samples the Nth bit.
REQ-022 On completion with q_valid=0, or with q_valid=1 and rd=1, q SHALL load the word and q_valid SHALL be 1.
REQ-023 On completion with q_valid=1 and rd=0, the new word SHALL be dropped, q SHALL be unchanged, and overrun SHALL be set to 1.
REQ-024 rd=1 with q_valid=1 and no completion in that cycle SHALL clear q_valid on the next edge; q SHALL keep its value.
REQ-025 rd=1 with q_valid=0 SHALL have no effect.
REQ-026 overrun SHALL stay 1 until reset.
REQ-027 busy SHALL equal 1 exactly when the state is RECV.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set state to IDLE, and clear the counter, shift register, q (to 0), q_valid, and overrun.
REQ-029 Reset SHALL override all other inputs in the same cycle, including mid-frame, and any partial frame SHALL be discarded.
REQ-030 The first frame after reset is released SHALL require a new sync.

Verification (N=4)
REQ-031 Reset, then sync+si_en with si=1, then si_en on 3 consecutive cycles with si=0,1,1 -> q=4'b1101 and q_valid=1 one edge after the 4th bit; busy=0 thereafter.
REQ-032 Word 0xD pending with rd=0, send a second frame with bits 0,0,0,0 -> q stays 0xD and overrun=1; pulse rd -> q_valid=0 while overrun stays 1.
REQ-033 Word pending, rd=1 asserted on the same cycle a new frame with bits 1,1,1,1 completes -> q=0xF, q_valid=1, overrun=0.
REQ-034 After 2 bits of a frame, assert sync with si_en=1, si=0, then send bits 1,1,1 -> q=4'b1110 with no earlier q_valid.
REQ-035 Assert reset after 3 bits of a frame -> busy=0, q=0, q_valid=0; then si_en pulses without sync -> no q_valid.
REQ-036 si_en gaps of 0-5 idle cycles between bits -> the same word as the back-to-back case, with completion one edge after the last bit.
